alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the core combinational ALU.
- Executes the RV32I integer ALU operation set in one registered cycle.
- Executes the RV32M multiply/divide set iteratively over XLEN cycles (M set gated by ALU_MEXT_EN).
- Sits in the execute stage; the controller issues operations with Start/Ready and stalls until Done.

Parameters:
- XLEN, 32: operand and result width; must be a power of two, at least 8.
- CNT_W, $clog2(XLEN)+1: iteration counter width (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Start  in  1  operation request; accepted when Start and Ready are both 1.
- SrcA  in  XLEN  operand A; sampled on accept.
- SrcB  in  XLEN  operand B or immediate; sampled on accept.
- opcode  in  7  RISC-V opcode; sampled on accept.
- funct3  in  3  RISC-V funct3; sampled on accept.
- funct7  in  7  RISC-V funct7; sampled on accept.
- Ready  out  1  block can accept an operation this cycle.
- Busy  out  1  iterative operation in progress.
- Done  out  1  one-cycle pulse: Result and Zero are valid and updated.
- Result  out  XLEN  registered result; holds until the next Done.
- Zero  out  1  registered; 1 when the Result written at Done is all zeros.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state=IDLE, Ready=1, Busy=0, Done=0, Result=0, Zero=1, counter=0.
- Reset mid-operation: aborts the operation; no Done is issued.
- FSM states: IDLE, CALC, DONE.
  - IDLE: accept -> DONE for a base op, CALC for an M op.
  - CALC: counter increments each cycle; after XLEN iterations -> DONE.
  - DONE: Done=1 for exactly one cycle; Result and Zero are written on the entry edge.
  - DONE then goes to IDLE, or re-accepts directly if Start=1.
- Ready=1 in IDLE and DONE; Ready=0 in CALC. Busy=1 only in CALC.
- Start while Ready=0 is ignored; the operands in flight are unaffected.
- Latency from the accept edge: base op Done on the next cycle (1); M op Done XLEN+1 cycles after accept.
- Back-to-back base ops give one result per cycle.
- Base ops are all mod 2^XLEN.
  - R-type (0110011, funct7[0]=0): ADD/SUB (funct7[5]), SLL, SLT, SLTU, XOR, SRL/SRA (funct7[5]), OR, AND.
  - Shift amount is SrcB[$clog2(XLEN)-1:0].
  - I-type (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI/SRAI.
  - Branch (1100011, any funct3): SrcA-SrcB.
  - Loads (0000011) and stores (0100011): SrcA+SrcB.
  - LUI (0110111): {SrcB[XLEN-1:12], 12'b0}.
  - JAL (1101111): 0.
  - Any unrecognised encoding: Result 0, 1-cycle latency.
- SLT/SLTI compare signed; SLTU/SLTIU compare unsigned. Result is 1 or 0, zero-extended.
- M ops (0110011, funct7=0000001):
  - MUL returns the low XLEN bits of the product.
  - MULH, MULHSU, MULHU return the high XLEN bits (signed×signed, signed×unsigned, unsigned×unsigned).
  - DIV/DIVU return the quotient, rounded toward zero; REM/REMU return the remainder, which takes the sign of the dividend.
  - Implementation: radix-2 shift-add or shift-subtract, one bit per CALC cycle.
  - Signed ops work on magnitudes and correct the sign at the end.
- Divide by zero: DIV/DIVU return all ones; REM/REMU return SrcA.
- Signed overflow (SrcA = most-negative, SrcB = -1): DIV returns most-negative; REM returns 0.
- Divide-by-zero and overflow still take the full XLEN+1 latency (fixed latency, no early-out).

Optional Feature:
- Macro: ALU_MEXT_EN.
- Defined: the M ops, the CALC state and the iterative datapath are compiled in, as described above.
- Undefined: the CALC state and datapath are removed and Busy is tied to 0.
  - funct7=0000001 R-type encodings are treated as unrecognised: Result 0, Done after 1 cycle.

Test Plan:
- Reset, then ADD 7+5 -> Done the cycle after accept, Result=12, Zero=0. SUB 5-5 -> Result=0, Zero=1.
- Start held for 3 cycles with SLT(-1,1), SLTU(-1,1), SRA(0x80000000,4) -> three consecutive Done pulses; Results 1, 0, 0xF8000000.
- MULH(0x80000000,0x80000000) -> Done exactly 33 cycles after accept, Result 0x40000000. Start pulsed mid-op is ignored and Ready=0 throughout.
- DIV(-7,2)=0xFFFFFFFD, REM(-7,2)=0xFFFFFFFF. DIVU(9,0)=0xFFFFFFFF, REMU(9,0)=9. DIV(0x80000000,-1)=0x80000000, REM=0.
- reset asserted on the 10th CALC cycle of a DIVU -> no Done; outputs return to reset values; the next ADD 1+1 gives Result 2 with 1-cycle latency.
- Built without ALU_MEXT_EN: MUL 3×4 -> Result 0, Zero=1, Done after 1 cycle, Busy never 1.

Source files
------------

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle RV32I ALU with iterative RV32M ops (M set compiled in with ALU_MEXT_EN)
module alu_mc #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  output logic            Ready,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result,
  output logic            Zero
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] F7_M   = 7'b0000001;

  // Clears the low 12 bits for LUI; for narrow XLEN this leaves nothing of SrcB
  localparam logic [XLEN-1:0] LUI_MASK = ~XLEN'(4095);

  if (XLEN < 8 || (XLEN & (XLEN - 1)) != 0 || CNT_W != $clog2(XLEN) + 1) begin : g_param_check
    $error("alu_mc: XLEN must be a power of two >= 8 and CNT_W must stay derived");
  end

`ifdef ALU_MEXT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd1, S_CALC = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd1} state_t;
`endif

  state_t r_state;
  state_t w_state_nxt;

  logic            w_accept;
  logic            w_is_m_enc;
  logic            w_m_op;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_add;
  logic [XLEN-1:0] w_sub;
  logic [XLEN-1:0] w_srl;
  logic [XLEN-1:0] w_sra;
  logic [XLEN-1:0] w_sll;
  logic [SHW-1:0]  w_shamt;
  logic            w_slt;
  logic            w_sltu;

  logic [XLEN-1:0] r_result;
  logic            r_zero;

  assign w_accept   = Start & Ready;
  assign w_is_m_enc = (opcode == OP_R) && (funct7 == F7_M);

  assign w_add   = SrcA + SrcB;
  assign w_sub   = SrcA - SrcB;
  assign w_shamt = SrcB[SHW-1:0];
  assign w_sll   = SrcA << w_shamt;
  assign w_srl   = SrcA >> w_shamt;
  assign w_sra   = $signed(SrcA) >>> w_shamt;
  assign w_slt   = $signed(SrcA) < $signed(SrcB);
  assign w_sltu  = SrcA < SrcB;

  // Single-cycle base-set result, computed straight from the issue-time operands
  always_comb begin
    w_base = '0;
    case (opcode)
      OP_R, OP_I: begin
        if (opcode == OP_I || (!w_is_m_enc && !funct7[0])) begin
          case (funct3)
            3'd0:    w_base = (opcode == OP_R && funct7[5]) ? w_sub : w_add;
            3'd1:    w_base = w_sll;
            3'd2:    w_base = {{(XLEN-1){1'b0}}, w_slt};
            3'd3:    w_base = {{(XLEN-1){1'b0}}, w_sltu};
            3'd4:    w_base = SrcA ^ SrcB;
            3'd5:    w_base = funct7[5] ? w_sra : w_srl;
            3'd6:    w_base = SrcA | SrcB;
            default: w_base = SrcA & SrcB;
          endcase
        end
      end
      OP_BR:        w_base = w_sub;
      OP_LD, OP_ST: w_base = w_add;
      OP_LUI:       w_base = SrcB & LUI_MASK;
      OP_JAL:       w_base = '0;
      default:      w_base = '0;
    endcase
  end

`ifdef ALU_MEXT_EN
  // Iterative datapath: r_acc holds {partial product} for MUL* and {remainder, quotient} for DIV*/REM*
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_mag;
  logic [XLEN-1:0]   r_srca;
  logic [2:0]        r_f3;
  logic              r_neg;
  logic              r_div0;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_last;
  logic              w_sa_eff;
  logic              w_sb_eff;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN:0]     w_msum;
  logic [2*XLEN-1:0] w_macc_nxt;
  logic [XLEN:0]     w_dshift;
  logic [XLEN:0]     w_ddiff;
  logic              w_dq;
  logic [2*XLEN-1:0] w_dacc_nxt;
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_q;
  logic [XLEN-1:0]   w_r;
  logic [XLEN-1:0]   w_m_res;

  assign w_m_op = w_is_m_enc;
  assign w_last = (r_cnt == CNT_W'(XLEN - 1));

  // Operand signedness: MULH/MULHSU treat A as signed, MULH treats B as signed, DIV/REM treat both as signed
  assign w_sa_eff = SrcA[XLEN-1] & (funct3[2] ? ~funct3[0] : (funct3[1] ^ funct3[0]));
  assign w_sb_eff = SrcB[XLEN-1] & (funct3[2] ? ~funct3[0] : (funct3 == 3'b001));
  assign w_a_mag  = w_sa_eff ? -SrcA : SrcA;
  assign w_b_mag  = w_sb_eff ? -SrcB : SrcB;

  // Shift-add step: add multiplicand to the upper half when the current multiplier bit is set
  assign w_msum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_mag : {XLEN{1'b0}})};
  assign w_macc_nxt = {w_msum, r_acc[XLEN-1:1]};

  // Restoring-divide step: the top bit of the difference is the borrow
  assign w_dshift   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_ddiff    = w_dshift - {1'b0, r_mag};
  assign w_dq       = ~w_ddiff[XLEN];
  assign w_dacc_nxt = {(w_dq ? w_ddiff[XLEN-1:0] : w_dshift[XLEN-1:0]), r_acc[XLEN-2:0], w_dq};

  assign w_acc_nxt = r_f3[2] ? w_dacc_nxt : w_macc_nxt;
  assign w_prod    = r_neg ? -w_acc_nxt : w_acc_nxt;
  assign w_q       = w_acc_nxt[XLEN-1:0];
  assign w_r       = w_acc_nxt[2*XLEN-1:XLEN];

  // Final M result from the last iteration, with sign correction and divide-by-zero overrides
  always_comb begin
    w_m_res = '0;
    if (!r_f3[2]) begin
      w_m_res = (r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end else if (!r_f3[1]) begin
      w_m_res = r_div0 ? {XLEN{1'b1}} : (r_neg ? -w_q : w_q);
    end else begin
      w_m_res = r_div0 ? r_srca : (r_neg ? -w_r : w_r);
    end
  end

  // Load magnitudes on accept of an M op, then advance one bit per CALC cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc  <= '0;
      r_mag  <= '0;
      r_srca <= '0;
      r_f3   <= '0;
      r_neg  <= 1'b0;
      r_div0 <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept && w_m_op) begin
      r_acc  <= {{XLEN{1'b0}}, (funct3[2] ? w_a_mag : w_b_mag)};
      r_mag  <= funct3[2] ? w_b_mag : w_a_mag;
      r_srca <= SrcA;
      r_f3   <= funct3;
      r_neg  <= (funct3[2] && funct3[1]) ? w_sa_eff : (w_sa_eff ^ w_sb_eff);
      r_div0 <= (SrcB == '0);
      r_cnt  <= '0;
    end else if (r_state == S_CALC) begin
      r_acc  <= w_acc_nxt;
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end
`else
  assign w_m_op = 1'b0;
`endif

  // Result and Zero are written only on the edge that enters DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
      r_zero   <= 1'b1;
    end else if (w_accept && !w_m_op) begin
      r_result <= w_base;
      r_zero   <= (w_base == '0);
`ifdef ALU_MEXT_EN
    end else if (r_state == S_CALC && w_last) begin
      r_result <= w_m_res;
      r_zero   <= (w_m_res == '0);
`endif
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: IDLE and DONE both accept, DONE can chain straight into the next op
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (!w_accept) begin
          w_state_nxt = S_IDLE;
`ifdef ALU_MEXT_EN
        end else if (w_m_op) begin
          w_state_nxt = S_CALC;
`endif
        end else begin
          w_state_nxt = S_DONE;
        end
      end
`ifdef ALU_MEXT_EN
      S_CALC: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: handshake flags decoded from the current state
  always_comb begin
    Ready = 1'b1;
    Busy  = 1'b0;
    Done  = 1'b0;
    case (r_state)
      S_DONE: Done = 1'b1;
`ifdef ALU_MEXT_EN
      S_CALC: begin
        Ready = 1'b0;
        Busy  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign Result = r_result;
  assign Zero   = r_zero;

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - randomized self-checking bench for alu_mc against a behavioural model
`timescale 1ns/1ps
module tb_alu_mc;

  localparam int XLEN = 32;
`ifdef ALU_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        Ready;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;
  logic        Zero;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_mc #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .reset  (reset),
    .Start  (Start),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .Ready  (Ready),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result),
    .Zero   (Zero)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // RV32M reference from plain arithmetic on 64-bit products and SV integer division
  function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (f3)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    int sh;
    sa = a;
    sb = b;
    sh = int'(b[4:0]);
    case (op)
      OP_R, OP_I: begin
        if (op == OP_R && f7 == 7'b0000001) return MEXT ? ref_m(f3, a, b) : 32'd0;
        if (op == OP_R && f7[0]) return 32'd0;
        case (f3)
          3'd0: return (op == OP_R && f7[5]) ? a - b : a + b;
          3'd1: return a << sh;
          3'd2: return (sa < sb) ? 32'd1 : 32'd0;
          3'd3: return (a < b) ? 32'd1 : 32'd0;
          3'd4: return a ^ b;
          3'd5: return f7[5] ? 32'(sa >>> sh) : a >> sh;
          3'd6: return a | b;
          default: return a & b;
        endcase
      end
      OP_BR:        return a - b;
      OP_LD, OP_ST: return a + b;
      OP_LUI:       return {b[31:12], 12'b0};
      default:      return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      4: return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op at a negedge and follow it to Done; poke_at>0 pulses Start with junk on that wait cycle
  task automatic run_op(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp, input int poke_at);
    int  exp_lat;
    int  lat;
    bit  wait_ok;
    exp_lat = (MEXT && op == OP_R && f7 == 7'b0000001) ? XLEN + 1 : 1;
    opcode = op; funct3 = f3; funct7 = f7; SrcA = a; SrcB = b; Start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    SrcA = $urandom; SrcB = $urandom; funct3 = 3'($urandom); opcode = OP_R; funct7 = 7'd0;
    lat = 1;
    wait_ok = 1'b1;
    while (Done !== 1'b1 && lat < 100) begin
      if (Busy !== 1'b1 || Ready !== 1'b0) wait_ok = 1'b0;
      if (lat == poke_at) begin
        Start = 1'b1; SrcA = 32'd1; SrcB = 32'd1; opcode = OP_R; funct3 = 3'd0; funct7 = 7'd0;
      end
      @(negedge clk);
      Start = 1'b0;
      lat++;
    end
    check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, " result"}, 64'(Result), 64'(exp));
    check_eq({tag, " zero"}, 64'(Zero), 64'(exp == 0));
    check_eq({tag, " busy at done"}, 64'(Busy), 64'd0);
    if (exp_lat > 1) check_eq({tag, " ready/busy during calc"}, 64'(wait_ok), 64'd1);
  endtask

  logic [6:0]  b2b_f7  [3] = '{7'h00, 7'h00, 7'h20};
  logic [2:0]  b2b_f3  [3] = '{3'd2, 3'd3, 3'd5};
  logic [31:0] b2b_a   [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
  logic [31:0] b2b_b   [3] = '{32'd1, 32'd1, 32'd4};
  logic [31:0] b2b_exp [3] = '{32'd1, 32'd0, 32'hF800_0000};
  logic [6:0]  rnd_ops [8] = '{OP_R, OP_R, OP_I, OP_BR, OP_LD, OP_ST, OP_LUI, OP_JAL};

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    bit          no_done;

    reset = 1'b1; Start = 1'b0; SrcA = '0; SrcB = '0; opcode = '0; funct3 = '0; funct7 = '0;
    repeat (3) @(negedge clk);
    check_eq("reset ready", 64'(Ready), 64'd1);
    check_eq("reset busy", 64'(Busy), 64'd0);
    check_eq("reset done", 64'(Done), 64'd0);
    check_eq("reset result", 64'(Result), 64'd0);
    check_eq("reset zero", 64'(Zero), 64'd1);
    reset = 1'b0;
    @(negedge clk);

    run_op("ADD 7+5", OP_R, 3'd0, 7'h00, 32'd7, 32'd5, 32'd12, 0);
    @(negedge clk);
    check_eq("done single pulse", 64'(Done), 64'd0);
    run_op("SUB 5-5", OP_R, 3'd0, 7'h20, 32'd5, 32'd5, 32'd0, 0);

    for (int i = 0; i < 3; i++) begin
      opcode = OP_R; funct3 = b2b_f3[i]; funct7 = b2b_f7[i]; SrcA = b2b_a[i]; SrcB = b2b_b[i]; Start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq($sformatf("back-to-back %0d done", i), 64'(Done), 64'd1);
      check_eq($sformatf("back-to-back %0d result", i), 64'(Result), 64'(b2b_exp[i]));
    end
    Start = 1'b0;
    @(negedge clk);

    run_op("LUI", OP_LUI, 3'd0, 7'h00, 32'd0, 32'hABCD_E123, 32'hABCD_E000, 0);
    run_op("MUL 3x4", OP_R, 3'd0, 7'h01, 32'd3, 32'd4, MEXT ? 32'd12 : 32'd0, 0);

`ifdef ALU_MEXT_EN
    run_op("MULH min*min", OP_R, 3'd1, 7'h01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 12);
    run_op("DIV -7/2",   OP_R, 3'd4, 7'h01, -32'd7, 32'd2, 32'hFFFF_FFFD, 0);
    run_op("REM -7%2",   OP_R, 3'd6, 7'h01, -32'd7, 32'd2, 32'hFFFF_FFFF, 0);
    run_op("DIVU 9/0",   OP_R, 3'd5, 7'h01, 32'd9, 32'd0, 32'hFFFF_FFFF, 0);
    run_op("REMU 9%0",   OP_R, 3'd7, 7'h01, 32'd9, 32'd0, 32'd9, 0);
    run_op("DIV ovf",    OP_R, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op("REM ovf",    OP_R, 3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
    run_op("MULHSU -1*3", OP_R, 3'd2, 7'h01, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 0);

    run_op("ADD before abort", OP_R, 3'd0, 7'h00, 32'd3, 32'd4, 32'd7, 0);
    opcode = OP_R; funct3 = 3'd5; funct7 = 7'h01; SrcA = 32'd1000; SrcB = 32'd7; Start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("abort busy before reset", 64'(Busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort ready", 64'(Ready), 64'd1);
    check_eq("abort busy", 64'(Busy), 64'd0);
    check_eq("abort result", 64'(Result), 64'd0);
    check_eq("abort zero", 64'(Zero), 64'd1);
    no_done = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (Done !== 1'b0) no_done = 1'b0;
      @(negedge clk);
    end
    check_eq("abort no done", 64'(no_done), 64'd1);
    run_op("ADD 1+1 after abort", OP_R, 3'd0, 7'h00, 32'd1, 32'd1, 32'd2, 0);
`endif

    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 9) == 0) op = 7'($urandom);
      else op = rnd_ops[$urandom_range(0, 7)];
      f3 = 3'($urandom);
      case ($urandom_range(0, 4))
        0, 1: f7 = 7'h00;
        2:    f7 = 7'h20;
        3:    f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      a = pick_operand();
      b = pick_operand();
      run_op($sformatf("rnd%0d op=%0h f3=%0d f7=%0h a=%0h b=%0h", n, op, f3, f7, a, b),
             op, f3, f7, a, b, ref_alu(op, f3, f7, a, b), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
